// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage of the RV32I pipeline: drives the data-memory
// req/ack bus for loads/stores and produces the registered regfile write port.
module mem_wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] pc_from_ex,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wr_n,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        misaligned
);

    typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, WB = 2'd2} state_t;

    state_t      state_r, state_s;
    logic        busy_r, mem_req_r, mem_we_r, wr_n_r, misaligned_r;
    logic [31:0] mem_addr_r, mem_wdata_r, wr_data_r, pc_r;
    logic [3:0]  mem_be_r;
    logic [4:0]  wr_addr_r, ld_rd_r;
    logic [2:0]  ld_funct3_r;
    logic [1:0]  ld_lane_r;

    logic        mem_we_s, wr_n_s, misaligned_s;
    logic [31:0] mem_addr_s, mem_wdata_s, wr_data_s, pc_s;
    logic [3:0]  mem_be_s;
    logic [4:0]  wr_addr_s, ld_rd_s;
    logic [2:0]  ld_funct3_s;
    logic [1:0]  ld_lane_s;

    logic is_load_s, is_store_s, is_alu_s, is_jump_s, is_mem_s, mis_s, accept_s;

    function automatic logic [31:0] load_extract(input logic [31:0] data,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] lane);
        logic [31:0] sh;
        sh = data >> {lane, 3'b000};
        case (f3)
            3'b000:  load_extract = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_extract = {24'h00_0000, sh[7:0]};
            3'b101:  load_extract = {16'h0000, sh[15:0]};
            default: load_extract = data;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            3'b000:  store_be = 4'b0001 << lane;
            3'b001:  store_be = 4'b0011 << lane;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            3'b000:  store_lanes = {4{sd[7:0]}};
            3'b001:  store_lanes = {2{sd[15:0]}};
            default: store_lanes = sd;
        endcase
    endfunction

    // Unknown widths (and unsigned stores) count as misaligned so they never reach the bus.
    function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic store);
        case (f3)
            3'b000:  access_misaligned = 1'b0;
            3'b001:  access_misaligned = lane[0];
            3'b010:  access_misaligned = (lane != 2'b00);
            3'b100:  access_misaligned = store;
            3'b101:  access_misaligned = store | lane[0];
            default: access_misaligned = 1'b1;
        endcase
    endfunction

    // Opcode class decode of the incoming instruction.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        is_alu_s   = 1'b0;
        is_jump_s  = 1'b0;
        case (opcode)
            7'b0000011: is_load_s  = 1'b1;
            7'b0100011: is_store_s = 1'b1;
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: is_alu_s = 1'b1;
            7'b1101111, 7'b1100111: is_jump_s = 1'b1;
            default: is_alu_s = 1'b0;
        endcase
    end

    assign is_mem_s = is_load_s | is_store_s;
    assign mis_s    = access_misaligned(funct3, alu_out[1:0], is_store_s);
    assign accept_s = in_valid && (state_r != MEM);

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            MEM: begin
                if (mem_ack) state_s = mem_we_r ? IDLE : WB;
                else         state_s = MEM;
            end
            IDLE, WB: begin
                if (!in_valid)                 state_s = IDLE;
                else if (is_mem_s && !mis_s)   state_s = MEM;
                else if (is_alu_s || is_jump_s) state_s = WB;
                else                           state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and the latched load context.
    always_comb begin
        mem_we_s     = mem_we_r;
        mem_addr_s   = mem_addr_r;
        mem_be_s     = mem_be_r;
        mem_wdata_s  = mem_wdata_r;
        wr_addr_s    = wr_addr_r;
        wr_data_s    = wr_data_r;
        ld_rd_s      = ld_rd_r;
        ld_funct3_s  = ld_funct3_r;
        ld_lane_s    = ld_lane_r;
        pc_s         = pc_r;
        wr_n_s       = 1'b1;
        misaligned_s = 1'b0;
        if (accept_s) begin
            pc_s = pc_from_ex;
            if (is_mem_s && mis_s) begin
                misaligned_s = 1'b1;
            end else if (is_mem_s) begin
                mem_we_s    = is_store_s;
                mem_addr_s  = {alu_out[31:2], 2'b00};
                mem_be_s    = is_store_s ? store_be(funct3, alu_out[1:0]) : 4'b1111;
                mem_wdata_s = is_store_s ? store_lanes(funct3, store_data) : 32'h0000_0000;
                ld_rd_s     = rd;
                ld_funct3_s = funct3;
                ld_lane_s   = alu_out[1:0];
            end else if (is_alu_s || is_jump_s) begin
                wr_n_s    = (rd == 5'd0);
                wr_addr_s = rd;
                wr_data_s = is_jump_s ? (pc_from_ex + 32'd4) : alu_out;
            end else begin
                wr_n_s = 1'b1;
            end
        end else if (state_r == MEM && mem_ack && !mem_we_r) begin
            wr_n_s    = (ld_rd_r == 5'd0);
            wr_addr_s = ld_rd_r;
            wr_data_s = load_extract(mem_rdata, ld_funct3_r, ld_lane_r);
        end else begin
            wr_n_s = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            mem_be_r     <= 4'b0000;
            mem_wdata_r  <= 32'h0000_0000;
            wr_n_r       <= 1'b1;
            wr_addr_r    <= 5'd0;
            wr_data_r    <= 32'h0000_0000;
            misaligned_r <= 1'b0;
            ld_rd_r      <= 5'd0;
            ld_funct3_r  <= 3'b000;
            ld_lane_r    <= 2'b00;
            pc_r         <= RESET_PC;
        end else begin
            state_r      <= state_s;
            busy_r       <= (state_s == MEM);
            mem_req_r    <= (state_s == MEM);
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_be_r     <= mem_be_s;
            mem_wdata_r  <= mem_wdata_s;
            wr_n_r       <= wr_n_s;
            wr_addr_r    <= wr_addr_s;
            wr_data_r    <= wr_data_s;
            misaligned_r <= misaligned_s;
            ld_rd_r      <= ld_rd_s;
            ld_funct3_r  <= ld_funct3_s;
            ld_lane_r    <= ld_lane_s;
            pc_r         <= pc_s;
        end
    end

    assign busy       = busy_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_be     = mem_be_r;
    assign mem_wdata  = mem_wdata_r;
    assign wr_n       = wr_n_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign misaligned = misaligned_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] pc_from_ex = 32'h0;
    logic [6:0]  opcode = 7'h0;
    logic [2:0]  funct3 = 3'h0;
    logic [31:0] alu_out = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [4:0]  rd = 5'h0;
    logic        busy, mem_req, mem_we, wr_n, misaligned;
    logic [31:0] mem_addr, mem_wdata, wr_data;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic [4:0]  wr_addr;

    int checks = 0;
    int failures = 0;
    int busy_cnt;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_ALU = 7'b0110011,
                           OP_IMM = 7'b0010011, OP_JAL = 7'b1101111, OP_BR = 7'b1100011;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pc_from_ex(pc_from_ex),
        .opcode(opcode), .funct3(funct3), .alu_out(alu_out), .store_data(store_data),
        .rd(rd), .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wr_n(wr_n), .wr_addr(wr_addr), .wr_data(wr_data), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] r, input logic [31:0] pc);
        in_valid = 1'b1; opcode = op; funct3 = f3; alu_out = a;
        store_data = sd; rd = r; pc_from_ex = pc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_mem_req"}, mem_req, 1'b0);
        check({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_be"}, mem_be, 4'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_wr_n"}, wr_n, 1'b1);
        check({tag, "_wr_addr"}, wr_addr, 5'd0);
        check({tag, "_wr_data"}, wr_data, 32'h0);
        check({tag, "_misaligned"}, misaligned, 1'b0);
    endtask

    initial begin
        step(); step();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // ADD rd=5
        issue(OP_ALU, 3'b000, 32'h1234, 32'h0, 5'd5, 32'h10);
        step();
        in_valid = 1'b0;
        check("add_wr_n", wr_n, 1'b0);
        check("add_wr_addr", wr_addr, 5'd5);
        check("add_wr_data", wr_data, 32'h1234);
        check("add_busy", busy, 1'b0);
        step();
        check("add_wr_n_after", wr_n, 1'b1);

        // back-to-back ADDI
        issue(OP_IMM, 3'b000, 32'hAAAA_0001, 32'h0, 5'd6, 32'h14);
        step();
        check("b2b0_wr_n", wr_n, 1'b0);
        check("b2b0_wr_addr", wr_addr, 5'd6);
        issue(OP_IMM, 3'b000, 32'hBBBB_0002, 32'h0, 5'd7, 32'h18);
        step();
        in_valid = 1'b0;
        check("b2b1_wr_n", wr_n, 1'b0);
        check("b2b1_wr_addr", wr_addr, 5'd7);
        check("b2b1_wr_data", wr_data, 32'hBBBB_0002);
        step();
        check("b2b_idle_wr_n", wr_n, 1'b1);

        // stray ack while idle must be ignored
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        check("stray_ack_wr_n", wr_n, 1'b1);
        check("stray_ack_req", mem_req, 1'b0);

        // LB at 0x103, three wait cycles
        issue(OP_LOAD, 3'b000, 32'h103, 32'h0, 5'd9, 32'h1C);
        step();
        in_valid = 1'b0;
        check("lb_req", mem_req, 1'b1);
        check("lb_we", mem_we, 1'b0);
        check("lb_addr", mem_addr, 32'h100);
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy) busy_cnt++;
        end
        mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
        step();
        mem_ack = 1'b0;
        check("lb_busy_cycles", busy_cnt, 4);
        check("lb_busy_fall", busy, 1'b0);
        check("lb_req_fall", mem_req, 1'b0);
        check("lb_wr_n", wr_n, 1'b0);
        check("lb_wr_addr", wr_addr, 5'd9);
        check("lb_wr_data", wr_data, 32'hFFFF_FF80);
        step();
        check("lb_wr_n_after", wr_n, 1'b1);

        // LHU at 0x12, zero wait cycles
        issue(OP_LOAD, 3'b101, 32'h12, 32'h0, 5'd10, 32'h20);
        step();
        in_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h8765_4321;
        step();
        mem_ack = 1'b0;
        check("lhu_wr_n", wr_n, 1'b0);
        check("lhu_wr_data", wr_data, 32'h0000_8765);
        step();

        // SH at 0x22, one wait cycle
        issue(OP_STORE, 3'b001, 32'h22, 32'hABCD_5678, 5'd3, 32'h24);
        step();
        in_valid = 1'b0;
        check("sh_req", mem_req, 1'b1);
        check("sh_we", mem_we, 1'b1);
        check("sh_addr", mem_addr, 32'h20);
        check("sh_be", mem_be, 4'b1100);
        check("sh_wdata", mem_wdata, 32'h5678_5678);
        step();
        check("sh_hold_be", mem_be, 4'b1100);
        check("sh_hold_busy", busy, 1'b1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("sh_busy_fall", busy, 1'b0);
        check("sh_no_write", wr_n, 1'b1);
        step();
        check("sh_no_write_late", wr_n, 1'b1);

        // SB at 0x1
        issue(OP_STORE, 3'b000, 32'h1, 32'h1234_56AB, 5'd3, 32'h28);
        step();
        in_valid = 1'b0;
        check("sb_be", mem_be, 4'b0010);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();

        // misaligned LW at 0x6
        issue(OP_LOAD, 3'b010, 32'h6, 32'h0, 5'd4, 32'h2C);
        step();
        in_valid = 1'b0;
        check("lw_mis_pulse", misaligned, 1'b1);
        check("lw_mis_req", mem_req, 1'b0);
        check("lw_mis_wr_n", wr_n, 1'b1);
        check("lw_mis_busy", busy, 1'b0);
        step();
        check("lw_mis_pulse_end", misaligned, 1'b0);
        check("lw_mis_req_later", mem_req, 1'b0);

        // BRANCH: no write
        issue(OP_BR, 3'b000, 32'h0, 32'h0, 5'd5, 32'h30);
        step();
        in_valid = 1'b0;
        check("br_no_write", wr_n, 1'b1);

        // JAL rd=1, then same with rd=0
        issue(OP_JAL, 3'b000, 32'h0, 32'h0, 5'd1, 32'h40);
        step();
        check("jal_wr_n", wr_n, 1'b0);
        check("jal_wr_addr", wr_addr, 5'd1);
        check("jal_wr_data", wr_data, 32'h44);
        rd = 5'd0;
        step();
        in_valid = 1'b0;
        check("jal_rd0_wr_n", wr_n, 1'b1);
        step();

        // reset asserted mid-MEM
        issue(OP_LOAD, 3'b010, 32'h200, 32'h0, 5'd8, 32'h48);
        step();
        in_valid = 1'b0;
        check("rstmem_req", mem_req, 1'b1);
        rst_n = 1'b0;
        step();
        check_reset_outputs("rstmem");
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_ack = 1'b0;
        check("late_ack_wr_n", wr_n, 1'b1);
        check("late_ack_req", mem_req, 1'b0);
        step();
        check("late_ack_wr_n2", wr_n, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
